csi2_lane_ctrl: RTL and testbench

CSI2_LANE_CTRL -- requirements
Module: csi2_lane_ctrl

---
 rtl/csi2_pkg.sv | 33 +++
 rtl/csi2_byte_counter.sv | 33 +++
 rtl/csi2_lane_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_csi2_lane_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// +----------------------------------------------------------------------+
// | csi2_pkg: shared states, error codes and DI threshold for CSI-2 lane |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package csi2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_HEADER    = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_FOOTER    = 3'd4,
    ST_DONE      = 3'd5
  } lane_state_e;

  localparam logic [1:0]  c_err_none         = 2'd0;
  localparam logic [1:0]  c_err_sync_timeout = 2'd1;
  localparam logic [1:0]  c_err_length       = 2'd2;
  localparam logic [1:0]  c_err_hs_drop      = 2'd3;

  // Data types below this value carry no payload (short packets)
  localparam logic [5:0]  c_long_di_min      = 6'h10;
  localparam logic [15:0] c_footer_bytes     = 16'd2;

  function automatic logic is_short_pkt(input logic [7:0] di);
    return (di[5:0] < c_long_di_min);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csi2_byte_counter.sv
// +----------------------------------------------------------------------+
// | csi2_byte_counter: loadable down-counter of valid bytes, zero flag   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module csi2_byte_counter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] r_count;

  // Saturates at zero so a stray decrement can never wrap the count
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (dec_i && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign zero_o = (r_count == 16'd0);

endmodule

`default_nettype wire

// File: rtl/csi2_lane_ctrl.sv
// +----------------------------------------------------------------------+
// | csi2_lane_ctrl: CSI-2 lane packet FSM (sync, header, payload, CRC)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module csi2_lane_ctrl
  import csi2_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 1023,
  parameter logic [15:0] MAX_WC       = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        hs_active_i,
  input  logic        aligned_valid_i,
  input  logic [7:0]  aligned_byte_i,
  output logic        align_enable_o,
  output logic        wait_for_sync_o,
  output logic        packet_done_o,
  output logic        hdr_valid_o,
  output logic [7:0]  hdr_di_o,
  output logic [15:0] hdr_wc_o,
  output logic [7:0]  hdr_ecc_o,
  output logic        payload_valid_o,
  output logic [7:0]  payload_byte_o,
  output logic        payload_last_o,
  output logic [1:0]  err_o
);

  localparam int unsigned c_sync_w = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  lane_state_e         r_state;
  lane_state_e         w_next;
  logic [c_sync_w-1:0] r_sync_cnt;
  logic [1:0]          r_hdr_idx;
  logic [7:0]          r_hdr_di;
  logic [15:0]         r_hdr_wc;
  logic [7:0]          r_hdr_ecc;
  logic                r_hdr_valid;
  logic                r_pl_valid;
  logic [7:0]          r_pl_byte;
  logic                r_pl_last;
  logic                r_done;
  logic [1:0]          r_err;

  logic                w_byte_ok;
  logic                w_sync_expired;
  logic                w_err_load;
  logic [1:0]          w_err_code;
  logic                w_cnt_load;
  logic [15:0]         w_cnt_val;
  logic                w_cnt_dec;
  logic                w_cnt_zero;

  assign w_byte_ok      = aligned_valid_i & hs_active_i;
  assign w_sync_expired = (r_sync_cnt == c_sync_w'(SYNC_TIMEOUT - 1));

  // Counter holds "bytes remaining minus one", so zero marks the final byte
  csi2_byte_counter u_byte_counter (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_cnt_load),
    .load_val_i (w_cnt_val),
    .dec_i      (w_cnt_dec),
    .zero_o     (w_cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_load = 1'b0;
    w_err_code = c_err_none;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (hs_active_i) w_next = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (aligned_valid_i) begin
          w_next = ST_HEADER;
        end else if (w_sync_expired) begin
          w_next     = ST_DONE;
          w_err_load = 1'b1;
          w_err_code = c_err_sync_timeout;
        end
      end
      ST_HEADER: begin
        if (!hs_active_i) begin
          w_next     = ST_DONE;
          w_err_load = 1'b1;
          w_err_code = c_err_hs_drop;
        end else if (aligned_valid_i && (r_hdr_idx == 2'd3)) begin
          // DI and both WC bytes are already registered when ECC arrives
          if (is_short_pkt(r_hdr_di)) begin
            w_next = ST_DONE;
          end else if (r_hdr_wc > MAX_WC) begin
            w_next     = ST_DONE;
            w_err_load = 1'b1;
            w_err_code = c_err_length;
          end else if (r_hdr_wc == 16'd0) begin
            w_next     = ST_FOOTER;
            w_cnt_load = 1'b1;
            w_cnt_val  = c_footer_bytes - 16'd1;
          end else begin
            w_next     = ST_PAYLOAD;
            w_cnt_load = 1'b1;
            w_cnt_val  = r_hdr_wc - 16'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!hs_active_i) begin
          w_next     = ST_DONE;
          w_err_load = 1'b1;
          w_err_code = c_err_hs_drop;
        end else if (aligned_valid_i) begin
          w_cnt_dec = 1'b1;
          if (w_cnt_zero) begin
            w_next     = ST_FOOTER;
            w_cnt_load = 1'b1;
            w_cnt_val  = c_footer_bytes - 16'd1;
          end
        end
      end
      ST_FOOTER: begin
        if (!hs_active_i) begin
          w_next     = ST_DONE;
          w_err_load = 1'b1;
          w_err_code = c_err_hs_drop;
        end else if (aligned_valid_i) begin
          w_cnt_dec = 1'b1;
          if (w_cnt_zero) w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!hs_active_i) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync_cnt <= '0;
      r_hdr_idx  <= '0;
    end else begin
      if (r_state == ST_WAIT_SYNC) r_sync_cnt <= r_sync_cnt + c_sync_w'(1);
      else                         r_sync_cnt <= '0;
      if (r_state != ST_HEADER)    r_hdr_idx  <= '0;
      else if (w_byte_ok)          r_hdr_idx  <= r_hdr_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hdr_di  <= '0;
      r_hdr_wc  <= '0;
      r_hdr_ecc <= '0;
    end else if ((r_state == ST_HEADER) && w_byte_ok) begin
      unique case (r_hdr_idx)
        2'd0:    r_hdr_di       <= aligned_byte_i;
        2'd1:    r_hdr_wc[7:0]  <= aligned_byte_i;
        2'd2:    r_hdr_wc[15:8] <= aligned_byte_i;
        default: r_hdr_ecc      <= aligned_byte_i;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hdr_valid <= 1'b0;
      r_pl_valid  <= 1'b0;
      r_pl_byte   <= '0;
      r_pl_last   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= c_err_none;
    end else begin
      r_hdr_valid <= (r_state == ST_HEADER) && w_byte_ok && (r_hdr_idx == 2'd3);
      r_pl_valid  <= (r_state == ST_PAYLOAD) && w_byte_ok;
      r_pl_last   <= (r_state == ST_PAYLOAD) && w_byte_ok && w_cnt_zero;
      if ((r_state == ST_PAYLOAD) && w_byte_ok) r_pl_byte <= aligned_byte_i;
      r_done      <= (w_next == ST_DONE) && (r_state != ST_DONE);
      if ((w_next == ST_WAIT_SYNC) && (r_state != ST_WAIT_SYNC)) r_err <= c_err_none;
      else if (w_err_load)                                       r_err <= w_err_code;
    end
  end

  assign align_enable_o  = (r_state != ST_IDLE);
  assign wait_for_sync_o = (r_state == ST_WAIT_SYNC);
  assign packet_done_o   = r_done;
  assign hdr_valid_o     = r_hdr_valid;
  assign hdr_di_o        = r_hdr_di;
  assign hdr_wc_o        = r_hdr_wc;
  assign hdr_ecc_o       = r_hdr_ecc;
  assign payload_valid_o = r_pl_valid;
  assign payload_byte_o  = r_pl_byte;
  assign payload_last_o  = r_pl_last;
  assign err_o           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_csi2_lane_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_csi2_lane_ctrl: randomized packet bench with reference model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_csi2_lane_ctrl;

  localparam logic [15:0] c_max_wc       = 16'h0040;
  localparam int          c_sync_timeout = 1023;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        hs_active_i = 1'b0;
  logic        aligned_valid_i = 1'b0;
  logic [7:0]  aligned_byte_i = 8'h00;
  logic        align_enable_o;
  logic        wait_for_sync_o;
  logic        packet_done_o;
  logic        hdr_valid_o;
  logic [7:0]  hdr_di_o;
  logic [15:0] hdr_wc_o;
  logic [7:0]  hdr_ecc_o;
  logic        payload_valid_o;
  logic [7:0]  payload_byte_o;
  logic        payload_last_o;
  logic [1:0]  err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  csi2_lane_ctrl #(
    .SYNC_TIMEOUT (c_sync_timeout),
    .MAX_WC       (c_max_wc)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .hs_active_i     (hs_active_i),
    .aligned_valid_i (aligned_valid_i),
    .aligned_byte_i  (aligned_byte_i),
    .align_enable_o  (align_enable_o),
    .wait_for_sync_o (wait_for_sync_o),
    .packet_done_o   (packet_done_o),
    .hdr_valid_o     (hdr_valid_o),
    .hdr_di_o        (hdr_di_o),
    .hdr_wc_o        (hdr_wc_o),
    .hdr_ecc_o       (hdr_ecc_o),
    .payload_valid_o (payload_valid_o),
    .payload_byte_o  (payload_byte_o),
    .payload_last_o  (payload_last_o),
    .err_o           (err_o)
  );

  // Output monitor: sole writer of the mon_* history
  logic [7:0]  mon_pl[$];
  int          mon_last[$];
  int          mon_hdr_cnt = 0;
  int          mon_done_cnt = 0;
  logic [1:0]  mon_err = 2'd0;
  logic [7:0]  mon_di = 8'h00;
  logic [15:0] mon_wc = 16'h0000;
  logic [7:0]  mon_ecc = 8'h00;

  always @(negedge clk_i) begin
    if (payload_valid_o) begin
      mon_pl.push_back(payload_byte_o);
      if (payload_last_o) mon_last.push_back(mon_pl.size() - 1);
    end else if (payload_last_o) begin
      mon_last.push_back(-1);
    end
    if (hdr_valid_o) begin
      mon_hdr_cnt++;
      mon_di  = hdr_di_o;
      mon_wc  = hdr_wc_o;
      mon_ecc = hdr_ecc_o;
    end
    if (packet_done_o) begin
      mon_done_cnt++;
      mon_err = err_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // gap < 0: exactly one idle cycle before every byte; otherwise percent chance
  task automatic run_packet(input string tag, input logic [7:0] di, input logic [15:0] wc,
                            input logic [7:0] ecc, input bit fixed_pl, input int gap,
                            input int drop_at);
    logic [7:0] stream[$];
    logic [7:0] exp_pl[$];
    bit         is_short;
    bit         len_err;
    bit         exp_last;
    bit         exp_hdr;
    logic [1:0] exp_err;
    int         pl_base;
    int         last_base;
    int         hdr_base;
    int         done_base;
    int         n;
    logic [7:0] b;

    is_short = (di[5:0] < 6'h10);
    len_err  = !is_short && (wc > c_max_wc);
    stream.push_back(di);
    stream.push_back(wc[7:0]);
    stream.push_back(wc[15:8]);
    stream.push_back(ecc);
    if (!is_short && !len_err) begin
      for (int i = 0; i < int'(wc); i++) begin
        b = fixed_pl ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        stream.push_back(b);
      end
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom));
    end
    if (!is_short && !len_err) begin
      for (int i = 4; i < 4 + int'(wc); i++)
        if (drop_at < 0 || i < drop_at) exp_pl.push_back(stream[i]);
    end
    exp_last = !is_short && !len_err && (wc != 16'd0) && (drop_at < 0 || drop_at >= 4 + int'(wc));
    exp_hdr  = (drop_at < 0) || (drop_at >= 4);
    if (drop_at >= 0 && drop_at < stream.size()) exp_err = 2'd3;
    else if (len_err)                            exp_err = 2'd2;
    else                                         exp_err = 2'd0;

    pl_base   = mon_pl.size();
    last_base = mon_last.size();
    hdr_base  = mon_hdr_cnt;
    done_base = mon_done_cnt;

    hs_active_i = 1'b1; aligned_valid_i = 1'b0; tick();
    check({tag, ":wait_for_sync"}, 32'(wait_for_sync_o), 32'd1);
    check({tag, ":align_enable"},  32'(align_enable_o),  32'd1);
    check({tag, ":err_cleared"},   32'(err_o),           32'd0);
    repeat ($urandom_range(0, 3)) tick();
    aligned_valid_i = 1'b1; aligned_byte_i = 8'($urandom); tick();
    for (int i = 0; i < stream.size(); i++) begin
      if (gap < 0) begin
        aligned_valid_i = 1'b0; tick();
      end else begin
        while ($urandom_range(0, 99) < gap) begin aligned_valid_i = 1'b0; tick(); end
      end
      aligned_valid_i = 1'b1; aligned_byte_i = stream[i];
      if (i == drop_at) begin hs_active_i = 1'b0; tick(); break; end
      tick();
    end
    aligned_valid_i = 1'b0; hs_active_i = 1'b0;
    repeat (4) tick();

    n = mon_pl.size() - pl_base;
    check({tag, ":pl_count"}, 32'(n), 32'(exp_pl.size()));
    for (int i = 0; i < exp_pl.size() && i < n; i++)
      check($sformatf("%s:pl_byte%0d", tag, i), 32'(mon_pl[pl_base + i]), 32'(exp_pl[i]));
    check({tag, ":last_count"}, 32'(mon_last.size() - last_base), 32'(exp_last));
    if (exp_last && mon_last.size() > last_base)
      check({tag, ":last_pos"}, 32'(mon_last[last_base]), 32'(pl_base + exp_pl.size() - 1));
    check({tag, ":hdr_valid_count"}, 32'(mon_hdr_cnt - hdr_base), 32'(exp_hdr));
    if (exp_hdr) begin
      check({tag, ":hdr_di"},  32'(mon_di),  32'(di));
      check({tag, ":hdr_wc"},  32'(mon_wc),  32'(wc));
      check({tag, ":hdr_ecc"}, 32'(mon_ecc), 32'(ecc));
    end
    check({tag, ":done_count"}, 32'(mon_done_cnt - done_base), 32'd1);
    check({tag, ":err"}, 32'(mon_err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         done_base;
    logic [7:0] di;
    logic [15:0] wc;
    int         drop;

    #2 rst_n_i = 1'b0;
    #2;
    check("reset:ctrl", 32'({align_enable_o, wait_for_sync_o, packet_done_o, hdr_valid_o,
                              payload_valid_o, payload_byte_o, payload_last_o, err_o}), 32'd0);
    check("reset:hdr", {hdr_di_o, hdr_wc_o, hdr_ecc_o}, 32'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
    check("idle:align_enable", 32'(align_enable_o), 32'd0);

    run_packet("short",  8'h00, 16'h3412, 8'hAB, 1'b0, 0, -1);
    run_packet("long4",  8'h2A, 16'd4, 8'($urandom), 1'b1, 0, -1);
    run_packet("hsdrop", 8'h2A, 16'd10, 8'($urandom), 1'b0, 0, 6);
    run_packet("gaps",   8'h2B, 16'd8, 8'($urandom), 1'b0, -1, -1);
    run_packet("lenerr", 8'h2C, 16'h0080, 8'($urandom), 1'b0, 20, -1);
    run_packet("wc0",    8'h12, 16'd0, 8'($urandom), 1'b0, 0, -1);
    run_packet("maxwc",  8'h1E, c_max_wc, 8'($urandom), 1'b0, 10, -1);
    run_packet("hdrdrop", 8'h2A, 16'd5, 8'($urandom), 1'b0, 0, 2);
    run_packet("ftrdrop", 8'h2A, 16'd5, 8'($urandom), 1'b0, 0, 10);

    for (int k = 0; k < 8; k++) begin
      di   = 8'($urandom);
      wc   = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(65, 90)) : 16'($urandom_range(0, 40));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_packet($sformatf("rand%0d", k), di, wc, 8'($urandom), 1'b0,
                 int'($urandom_range(0, 60)), drop);
    end

    // Sync timeout: HS held with no aligned bytes
    done_base = mon_done_cnt;
    hs_active_i = 1'b1; aligned_valid_i = 1'b0;
    n = 0;
    while (packet_done_o !== 1'b1 && n < c_sync_timeout + 50) begin
      tick(); n++;
      if (n == 10) check("timeout:wait_for_sync", 32'(wait_for_sync_o), 32'd1);
    end
    check("timeout:cycles", 32'(n), 32'(c_sync_timeout + 1));
    check("timeout:err", 32'(err_o), 32'd1);
    hs_active_i = 1'b0;
    repeat (3) tick();
    check("timeout:done_count", 32'(mon_done_cnt - done_base), 32'd1);
    check("timeout:back_idle", 32'(align_enable_o), 32'd0);

    // Reset in the middle of a payload
    done_base = mon_done_cnt;
    hs_active_i = 1'b1; tick();
    aligned_valid_i = 1'b1; aligned_byte_i = 8'hB8; tick();
    aligned_byte_i = 8'h2A; tick();
    aligned_byte_i = 8'h14; tick();
    aligned_byte_i = 8'h00; tick();
    aligned_byte_i = 8'h5C; tick();
    for (int i = 0; i < 5; i++) begin aligned_byte_i = 8'($urandom); tick(); end
    #3 rst_n_i = 1'b0;
    #1;
    check("midrst:ctrl", 32'({align_enable_o, wait_for_sync_o, packet_done_o, hdr_valid_o,
                              payload_valid_o, payload_byte_o, payload_last_o, err_o}), 32'd0);
    check("midrst:hdr", {hdr_di_o, hdr_wc_o, hdr_ecc_o}, 32'd0);
    hs_active_i = 1'b0; aligned_valid_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    repeat (3) tick();
    check("midrst:no_done", 32'(mon_done_cnt - done_base), 32'd0);
    check("midrst:idle", 32'(align_enable_o), 32'd0);

    run_packet("postrst", 8'h2A, 16'd3, 8'($urandom), 1'b0, 30, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
